// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU adder datapath.
// Control vectors are packed as {invert_a, invert_b, cin}.
package alu_pkg;
    localparam int WIDTH = 32;
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_RSB = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b100;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;
endpackage

// File: rtl/rp_adder32_if.sv
// Operand/control and result/flag bundle for rp_adder32.
// The master drives operands, and the slave returns result and flags.
interface rp_adder32_if;
    import alu_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             invert_a;
    logic             invert_b;
    logic             cin;
    logic             isactive;
    logic [WIDTH-1:0] result;
    logic             N;
    logic             Z;
    logic             C;
    logic             V;
    logic             valid_out;

    modport master (
        output a, b, invert_a, invert_b, cin, isactive,
        input  result, N, Z, C, V, valid_out
    );

    modport slave (
        input  a, b, invert_a, invert_b, cin, isactive,
        output result, N, Z, C, V, valid_out
    );
endinterface

// File: rtl/full_adder_bit.sv
// Single-bit full adder cell used to build the ripple-carry chain.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/rp_adder32.sv
// Registered add/subtract core with operand inversion and NZCV flags.
module rp_adder32 #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    rp_adder32_if.slave  bus
);
    import alu_pkg::*;

    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;
    flags_t           flg_d;
    flags_t           flg_q;
    logic [WIDTH-1:0] result_q;
    logic             valid_q;

    assign a_eff    = bus.a ^ {WIDTH{bus.invert_a}};
    assign b_eff    = bus.b ^ {WIDTH{bus.invert_b}};
    assign carry[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_bit u_fa (
            .a  (a_eff[i]),
            .b  (b_eff[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    always_comb begin
        flg_d   = '0;
        flg_d.n = sum[WIDTH-1];
        flg_d.z = (sum == '0);
        flg_d.c = carry[WIDTH];
        // Overflow: like-signed operands producing an opposite-signed sum.
        flg_d.v = (a_eff[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum[WIDTH-1] != a_eff[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flg_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= bus.isactive;
            if (bus.isactive) begin
                result_q <= sum;
                flg_q    <= flg_d;
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.N         = flg_q.n;
    assign bus.Z         = flg_q.z;
    assign bus.C         = flg_q.c;
    assign bus.V         = flg_q.v;
    assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_rp_adder32.sv
// Directed and random checks for rp_adder32 against a wide-sum model.
module tb_rp_adder32;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    rp_adder32_if bus ();

    rp_adder32 #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [2:0]  ctl,
                         input logic        act);
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.invert_a = ctl[2];
        bus.invert_b = ctl[1];
        bus.cin      = ctl[0];
        bus.isactive = act;
        @(posedge clk);
        #1;
    endtask

    // exp_f is {N,Z,C,V,valid_out}
    task automatic expect_out(input string tag,
                              input logic [31:0] exp_r,
                              input logic [4:0]  exp_f);
        check({tag, ".res"}, {32'h0, bus.result}, {32'h0, exp_r});
        check({tag, ".flg"},
              {59'h0, bus.N, bus.Z, bus.C, bus.V, bus.valid_out},
              {59'h0, exp_f});
    endtask

    task automatic run_random(input int count);
        logic [31:0] ra, rb, ae, be;
        logic [2:0]  rc;
        logic [63:0] wide;
        logic [31:0] s;
        logic [4:0]  f;
        for (int i = 0; i < count; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 3'($urandom_range(0, 7));
            drive(ra, rb, rc, 1'b1);
            ae   = rc[2] ? ~ra : ra;
            be   = rc[1] ? ~rb : rb;
            wide = {32'h0, ae} + {32'h0, be} + {63'h0, rc[0]};
            s    = wide[31:0];
            f[4] = s[31];
            f[3] = (s == 32'h0);
            f[2] = wide[32];
            f[1] = (ae[31] == be[31]) && (s[31] != ae[31]);
            f[0] = 1'b1;
            expect_out("rand", s, f);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.a = '0; bus.b = '0;
        bus.invert_a = 0; bus.invert_b = 0;
        bus.cin = 0; bus.isactive = 0;

        for (int i = 0; i < 2; i++) begin
            drive($urandom, $urandom, 3'($urandom_range(0, 7)), 1'b1);
            expect_out("reset", 32'h0, 5'b0000_0);
        end
        @(negedge clk);
        rst = 1'b0;

        drive(32'd5, 32'd3, OP_ADD, 1'b1);
        expect_out("add", 32'd8, 5'b0000_1);
        drive(32'd1, 32'd1, 3'b001, 1'b1);
        expect_out("adc", 32'd3, 5'b0000_1);
        drive(32'd5, 32'd5, OP_SUB, 1'b1);
        expect_out("sub_eq", 32'h0, 5'b0110_1);
        drive(32'd3, 32'd5, OP_SUB, 1'b1);
        expect_out("sub_neg", 32'hFFFFFFFE, 5'b1000_1);
        drive(32'd3, 32'd10, OP_RSB, 1'b1);
        expect_out("rsb", 32'd7, 5'b0010_1);
        drive(32'h7FFFFFFF, 32'd1, OP_ADD, 1'b1);
        expect_out("ovf", 32'h80000000, 5'b1001_1);
        drive(32'hFFFFFFFF, 32'd1, OP_ADD, 1'b1);
        expect_out("wrap", 32'h0, 5'b0110_1);
        drive(32'd1, 32'd2, 3'b111, 1'b1);
        expect_out("inv_both", 32'hFFFFFFFC, 5'b1010_1);
        drive(32'h0, 32'h0, OP_NOT, 1'b1);
        expect_out("not", ALL_ONES, 5'b1000_1);
        drive(32'd7, 32'd0, OP_ADD, 1'b0);
        expect_out("hold", ALL_ONES, 5'b1000_0);
        drive(32'd9, 32'd9, OP_ADD, 1'b0);
        expect_out("hold2", ALL_ONES, 5'b1000_0);

        @(negedge clk);
        rst = 1'b1;
        drive(32'd4, 32'd4, OP_ADD, 1'b1);
        expect_out("rst_prio", 32'h0, 5'b0000_0);
        @(negedge clk);
        rst = 1'b0;

        run_random(10000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
